// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit driving the register-file write port; one op in flight.
// Define RV_MULDIV_FAST_MUL_EN for a single-cycle multiplier (divide path unchanged).
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int ITERATIONS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [4:0]      write_address,
  output logic [XLEN-1:0] write_data,
  output logic            write_enable
);

  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`ifdef RV_MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mag;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_special;
  logic              r_done;
  logic              r_we;
  logic [4:0]        r_waddr;
  logic [XLEN-1:0]   r_wdata;

  logic              w_mul_op;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_special_res;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_part;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;

  // Operand signedness: MULHU, DIVU, REMU are fully unsigned; MULHSU only treats rs1 as signed.
  assign w_mul_op = ~funct3[2];
  assign w_a_neg  = operand1[XLEN-1] & (w_mul_op ? (funct3 != 3'd3) : ~funct3[0]);
  assign w_b_neg  = operand2[XLEN-1] & (w_mul_op ? ~funct3[1] : ~funct3[0]);
  assign w_mag1   = w_a_neg ? -operand1 : operand1;
  assign w_mag2   = w_b_neg ? -operand2 : operand2;

  assign w_div_zero    = funct3[2] & (operand2 == '0);
  assign w_div_ovf     = funct3[2] & ~funct3[0] & (operand1 == MIN_NEG) & (&operand2);
  assign w_special_res = w_div_zero ? (funct3[1] ? operand1 : '1)
                                    : (funct3[1] ? '0 : MIN_NEG);

`ifdef RV_MULDIV_FAST_MUL_EN
  assign w_mul_next = {{XLEN{1'b0}}, r_mag} * {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
`else
  logic [XLEN:0] w_add;
  assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag} : '0);
  assign w_mul_next = {w_add, r_acc[XLEN-1:1]};
`endif

  // Partial remainder keeps the shifted-out top bit so divisors >= 2^31 compare correctly.
  assign w_part     = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge       = (w_part >= {1'b0, r_mag});
  assign w_diff     = w_part[XLEN-1:0] - r_mag;
  assign w_div_next = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                           : {w_part[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_result = '0;
    if (r_special)
      w_result = r_acc[XLEN-1:0];
    else if (!r_op[2])
      w_result = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else
      w_result = r_op[1] ? w_rem : w_quo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mag     <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_we   <= 1'b0;
          r_cnt  <= '0;
          if (start) begin
            r_op      <= funct3;
            r_rd      <= rd_in;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_special <= w_div_zero | w_div_ovf;
            // Multiply: rs1 magnitude is the addend, rs2 shifts out of the low half.
            r_mag     <= w_mul_op ? w_mag1 : w_mag2;
            if (w_div_zero | w_div_ovf) begin
              r_acc   <= {{XLEN{1'b0}}, w_special_res};
              r_state <= S_DONE;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, (w_mul_op ? w_mag2 : w_mag1)};
              r_state <= w_mul_op ? S_MUL : S_DIV;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (FAST_MUL || r_cnt == LAST) r_state <= S_DONE;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_DONE;
        end
        S_DONE: begin
          // Sign fix-up and result select happen here; the write port sees it next cycle.
          r_done  <= 1'b1;
          r_we    <= (r_rd != 5'd0);
          r_waddr <= r_rd;
          r_wdata <= w_result;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign write_enable  = r_we;
  assign write_address = r_waddr;
  assign write_data    = r_wdata;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands and produces a write-back triple (write_address, write_data, write_enable) that drives the register file write port directly.
- One operation in flight at a time.
- Radix-2 shift-add multiplier and restoring divider, sharing one 64-bit working register.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERATIONS, 32, iteration cycles per operation; must equal XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand1  input  32  rs1 value from register file read_data1.
- operand2  input  32  rs2 value from register file read_data2.
- rd_in  input  5  destination register index.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- write_address  output  5  captured rd_in; valid while done.
- write_data  output  32  result; valid while done.
- write_enable  output  1  done && captured rd != 0.

Behaviour:
- Clock and reset: one clock (clk). Reset (reset) is synchronous and active-high.
- Reset values: state IDLE; busy, done, write_enable = 0; write_address = 0; write_data = 0.
- Reset mid-operation: the operation is abandoned, the next cycle is IDLE, and no write is ever issued for it.

State machine (IDLE, MUL, DIV, DONE):
- IDLE:
  - start=1 at edge E0 captures funct3, operand1, operand2 and rd_in.
  - Next state is MUL (funct3[2]=0) or DIV (funct3[2]=1).
  - Special-case divides go directly to DONE.
- MUL / DIV: exactly 32 iteration cycles, iteration counter 0..31, then DONE.
- DONE:
  - Lasts exactly one cycle; done=1 and write_enable as defined above.
  - Then returns to IDLE.
  - start during DONE is ignored.
- start while busy is ignored. The caller must hold the request until busy=0.
- Latency: done is high in the cycle after edge E0+33 (normal path) or after E0+1 (special-case divide).
- Outputs are registered. write_data and write_address are stable only while done=1 and are don't-care otherwise.

Multiply:
- Operands are converted to magnitudes according to signedness:
  - MUL/MULH: both signed.
  - MULHSU: operand1 signed, operand2 unsigned.
  - MULHU: both unsigned.
- 32 shift-add steps build a 64-bit unsigned product.
- The product is negated if the signs differ.
- MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.

Divide:
- Restoring algorithm on magnitudes; quotient and remainder come from the working register.
- Signed quotient is negated if the signs differ.
- Signed remainder takes the sign of the dividend.

Special cases (1-cycle path):
- Divisor 0:
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return operand1.
- Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only):
  - DIV returns 0x80000000.
  - REM returns 0.

Boundary rules:
- Captured operands are immune to operand changes after E0.
- rd_in = 0: the operation still runs and done still pulses, but write_enable stays 0.

Optional Feature:
- Macro: RV_MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops use a single-cycle combinational 64-bit signed/unsigned product.
  - MUL state lasts one cycle, so done is high in the cycle after E0+2.
- Not defined:
  - 32-cycle iterative multiplier as above.
- Divide timing, port list, and reset behaviour are identical in both builds.

Test Plan:
1. MUL 7 × 0xFFFFFFFD, rd=5:
   - busy=1 after E0.
   - done=1 and write_enable=1 exactly one cycle, after E0+33.
   - write_address=5, write_data=0xFFFFFFEB.
2. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
4. Special cases, each with done after E0+1:
   - DIVU 5/0 → 0xFFFFFFFF.
   - REM 5/0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM same operands → 0.
5. Start DIV, then:
   - Second start pulse at iteration 4 is ignored: only one done.
   - New run: assert reset at iteration 10; busy=0 next cycle, done and write_enable never asserted, next start behaves normally.
6. MUL 3 × 4 with rd=0 → done pulses, write_enable stays 0. Repeat under RV_MULDIV_FAST_MUL_EN: result 12 with done after E0+2.
